// File: rtl/cfg_chain_pkg.sv
// Shared types and helpers for the configuration chain driver.
package cfg_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } cfg_state_t;

  // Bit-counter width able to hold 0..size.
  function automatic int unsigned cnt_width(input int unsigned size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/cfg_piso_capture.sv
// Parallel-in/serial-out transmit register plus serial-in capture of the
// returning chain data; both advance on the same shift enable.
module cfg_piso_capture #(
  parameter int unsigned SIZE = 32
) (
  input  logic            Clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic            shift_en,
  input  logic            last,
  input  logic [SIZE-1:0] word,
  input  logic            ser_in,
  output logic            ser_out,
  output logic [SIZE-1:0] rb
);

  logic [SIZE-1:0] tx;

  // Load word, then present one bit per shift; ser_out drops to 0 after the last bit.
  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      tx      <= '0;
      ser_out <= 1'b0;
      rb      <= '0;
    end else if (load_en) begin
      tx      <= word;
      ser_out <= word[SIZE-1];
    end else if (shift_en) begin
      tx      <= tx << 1;
      ser_out <= last ? 1'b0 : tx[SIZE-2];
      rb      <= {rb[SIZE-2:0], ser_in};
    end
  end

endmodule

// File: rtl/config_chain_driver.sv
// Serialises a config word MSB-first into the shift chain, pulses Load,
// and captures the chain's previous contents as Readback.
module config_chain_driver
  import cfg_chain_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic            Clk,
  input  logic            rst_n,
  input  logic            Cmd_Valid,
  output logic            Cmd_Ready,
  input  logic [SIZE-1:0] Cmd_Word,
  input  logic            Cmd_No_Load,
  output logic            Shift_En,
  output logic            Serial_Data,
  input  logic            Serial_Return,
  output logic            Load,
  output logic            Done,
  output logic [SIZE-1:0] Readback,
  output logic            Busy
);

  localparam int unsigned CNT_W = cnt_width(SIZE);

  cfg_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             no_load_q;
  logic             accept_c;
  logic             last_c;
  logic             shift_en_nxt, load_nxt, done_nxt, ready_nxt;
  logic [SIZE-1:0]  rb;

  assign accept_c = (state == IDLE) && Cmd_Valid;
  assign last_c   = (cnt == CNT_W'(SIZE - 1));

  // Next state and next values of the registered strobes.
  always_comb begin
    state_nxt    = state;
    shift_en_nxt = 1'b0;
    load_nxt     = 1'b0;
    done_nxt     = 1'b0;
    ready_nxt    = 1'b0;
    case (state)
      IDLE:    if (Cmd_Valid) state_nxt = SHIFT;
      SHIFT:   if (last_c) state_nxt = no_load_q ? DONE : LOAD;
      LOAD:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    shift_en_nxt = (state_nxt == SHIFT);
    load_nxt     = (state_nxt == LOAD);
    done_nxt     = (state_nxt == DONE);
    ready_nxt    = (state_nxt == IDLE);
  end

  // State, counter, command flag and output registers.
  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      no_load_q <= 1'b0;
      Shift_En  <= 1'b0;
      Load      <= 1'b0;
      Done      <= 1'b0;
      Cmd_Ready <= 1'b1;
      Busy      <= 1'b0;
      Readback  <= '0;
    end else begin
      state     <= state_nxt;
      Shift_En  <= shift_en_nxt;
      Load      <= load_nxt;
      Done      <= done_nxt;
      Cmd_Ready <= ready_nxt;
      Busy      <= !ready_nxt;
      if (accept_c) begin
        cnt       <= '0;
        no_load_q <= Cmd_No_Load;
      end else if (state == SHIFT) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == DONE) Readback <= rb;
    end
  end

  cfg_piso_capture #(
    .SIZE(SIZE)
  ) u_piso (
    .Clk      (Clk),
    .rst_n    (rst_n),
    .load_en  (accept_c),
    .shift_en (state == SHIFT),
    .last     (last_c),
    .word     (Cmd_Word),
    .ser_in   (Serial_Return),
    .ser_out  (Serial_Data),
    .rb       (rb)
  );

endmodule

// File: tb/tb_config_chain_driver.sv
// Driver paired with a behavioural shift chain; per-cycle strobe checks
// against command-level expectations plus readback/latch bookkeeping.
module tb_config_chain_driver;

  localparam int unsigned SIZE = 8;

  logic            clk;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [SIZE-1:0] cmd_word;
  logic            cmd_no_load;
  logic            shift_en;
  logic            serial_data;
  logic            serial_return;
  logic            load;
  logic            done;
  logic [SIZE-1:0] readback;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Chain model: shift register clocked by Clk gated with Shift_En, plus latch.
  logic [SIZE-1:0] chain_sr    = 8'h5A;
  logic [SIZE-1:0] chain_latch = 8'h00;

  // Reference: what the chain holds / has latched at command granularity.
  logic [SIZE-1:0] m_sr    = 8'h5A;
  logic [SIZE-1:0] m_latch = 8'h00;

  assign serial_return = chain_sr[SIZE-1];

  always @(posedge clk) begin
    if (shift_en) chain_sr <= {chain_sr[SIZE-2:0], serial_data};
    if (load) chain_latch <= chain_sr;
  end

  config_chain_driver #(.SIZE(SIZE)) dut (
    .Clk           (clk),
    .rst_n         (rst_n),
    .Cmd_Valid     (cmd_valid),
    .Cmd_Ready     (cmd_ready),
    .Cmd_Word      (cmd_word),
    .Cmd_No_Load   (cmd_no_load),
    .Shift_En      (shift_en),
    .Serial_Data   (serial_data),
    .Serial_Return (serial_return),
    .Load          (load),
    .Done          (done),
    .Readback      (readback),
    .Busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for ready at a negedge.
  task automatic wait_ready();
    int w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 64'(cmd_ready), 64'd1);
  endtask

  // One complete command; when hold=1, Cmd_Valid stays high and inputs churn.
  task automatic run_cmd(input logic [SIZE-1:0] w, input bit nl, input bit hold);
    logic [SIZE-1:0] exp_rb;
    int              done_c;
    logic            ser_exp;
    wait_ready();
    cmd_valid   = 1'b1;
    cmd_word    = w;
    cmd_no_load = nl;
    exp_rb      = m_sr;
    done_c      = nl ? SIZE + 1 : SIZE + 2;
    @(posedge clk);
    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      if (!hold && c == 1) cmd_valid = 1'b0;
      if (hold && c <= done_c) begin
        cmd_word    = SIZE'($urandom);
        cmd_no_load = 1'($urandom);
      end
      ser_exp = (c <= SIZE) ? w[SIZE-c] : 1'b0;
      chk("shift_en", 64'(shift_en), 64'(c <= SIZE));
      chk("serial_data", 64'(serial_data), 64'(ser_exp));
      chk("load", 64'(load), 64'(!nl && c == SIZE + 1));
      chk("done", 64'(done), 64'(c == done_c));
      chk("cmd_ready", 64'(cmd_ready), 64'(c == done_c + 1));
      chk("busy", 64'(busy), 64'(c != done_c + 1));
    end
    m_sr = w;
    if (!nl) m_latch = w;
    chk("readback", 64'(readback), 64'(exp_rb));
    chk("chain_sr", 64'(chain_sr), 64'(m_sr));
    chk("chain_latch", 64'(chain_latch), 64'(m_latch));
  endtask

  initial begin
    bit prev_hold;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_word    = '0;
    cmd_no_load = 1'b0;

    // Reset held two cycles
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_shift_en", 64'(shift_en), 64'd0);
    chk("rst_serial", 64'(serial_data), 64'd0);
    chk("rst_load", 64'(load), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_readback", 64'(readback), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: first write, load vs readback-only, held valid
    run_cmd(8'hA5, 1'b0, 1'b0);
    run_cmd(8'h3C, 1'b0, 1'b0);
    run_cmd(8'h00, 1'b1, 1'b0);
    chk("noload_latch_kept", 64'(chain_latch), 64'h3C);
    run_cmd(SIZE'($urandom), 1'b0, 1'b1);
    run_cmd(SIZE'($urandom), 1'b0, 1'b0);

    // Reset during shift cycle 4 of 0xFF
    wait_ready();
    cmd_valid   = 1'b1;
    cmd_word    = 8'hFF;
    cmd_no_load = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      chk("abort_shift_en", 64'(shift_en), 64'd1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    m_sr = {m_sr[SIZE-5:0], 4'hF};
    chk("abort_shift_en_off", 64'(shift_en), 64'd0);
    chk("abort_serial", 64'(serial_data), 64'd0);
    chk("abort_load", 64'(load), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_ready", 64'(cmd_ready), 64'd1);
    chk("abort_readback", 64'(readback), 64'd0);
    chk("abort_chain_sr", 64'(chain_sr), 64'(m_sr));
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_load", 64'(load), 64'd0);
    chk("abort_latch", 64'(chain_latch), 64'(m_latch));
    run_cmd(8'hC3, 1'b0, 1'b0);

    // Randomized commands, idle gaps and held-valid streaks
    prev_hold = 1'b0;
    for (int i = 0; i < 24; i++) begin
      bit hold;
      hold = (i < 23) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      if (!prev_hold) begin
        int gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          cmd_word = SIZE'($urandom);
          @(negedge clk);
        end
      end
      run_cmd(SIZE'($urandom), 1'($urandom_range(0, 2) == 0), hold);
      prev_hold = hold;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
